// File: rtl/ddr_axi_rd_arbiter.sv
// ddr_axi_rd_arbiter: round-robin arbiter granting whole AXI4 read bursts from N masters onto one DDR read port,
// with a per-burst beat-count check against ARLEN.
module ddr_axi_rd_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int ID_W = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*ID_W-1:0]     s_arid,
  input  logic [N_MASTERS*ADDR_W-1:0]   s_araddr,
  input  logic [N_MASTERS*8-1:0]        s_arlen,
  input  logic [N_MASTERS*3-1:0]        s_arsize,
  input  logic [N_MASTERS*2-1:0]        s_arburst,
  input  logic [N_MASTERS-1:0]          s_arvalid,
  output logic [N_MASTERS-1:0]          s_arready,
  output logic [N_MASTERS*ID_W-1:0]     s_rid,
  output logic [N_MASTERS*DATA_W-1:0]   s_rdata,
  output logic [N_MASTERS*2-1:0]        s_rresp,
  output logic [N_MASTERS-1:0]          s_rlast,
  output logic [N_MASTERS-1:0]          s_rvalid,
  input  logic [N_MASTERS-1:0]          s_rready,
  output logic [ID_W-1:0]               m_arid,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [ID_W-1:0]               m_rid,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          busy,
  output logic                          len_err
);
  localparam int N = N_MASTERS;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state;
  logic [N-1:0] r_grant;
  logic [LW-1:0] r_last, r_gidx, w_pick, w_cand;
  logic [LW:0] w_sum;
  logic [7:0] r_beat_cnt, r_len_q;
  logic w_beat;
  // Scan from furthest to nearest after r_last so the nearest requester is the one left in w_pick.
  always_comb begin
    w_pick = r_last;
    w_sum = '0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_sum = {1'b0, r_last} + (LW+1)'(k);
      w_cand = LW'(w_sum >= (LW+1)'(N) ? w_sum - (LW+1)'(N) : w_sum);
      if (s_arvalid[w_cand]) w_pick = w_cand;
    end
  end
  always_comb begin
    m_arid = '0;
    m_araddr = '0;
    m_arlen = '0;
    m_arsize = '0;
    m_arburst = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        m_arid = m_arid | s_arid[i*ID_W +: ID_W];
        m_araddr = m_araddr | s_araddr[i*ADDR_W +: ADDR_W];
        m_arlen = m_arlen | s_arlen[i*8 +: 8];
        m_arsize = m_arsize | s_arsize[i*3 +: 3];
        m_arburst = m_arburst | s_arburst[i*2 +: 2];
      end
    end
  end
  assign grant = r_grant;
  assign busy = r_state != IDLE;
  assign m_arvalid = r_state == ADDR;
  assign s_arready = (m_arvalid && m_arready) ? r_grant : '0;
  assign m_rready = (r_state == DATA) && |(r_grant & s_rready);
  assign s_rvalid = (r_state == DATA && m_rvalid) ? r_grant : '0;
  assign s_rlast = (r_state == DATA && m_rlast) ? r_grant : '0;
  assign s_rid = {N{m_rid}};
  assign s_rdata = {N{m_rdata}};
  assign s_rresp = {N{m_rresp}};
  assign w_beat = m_rvalid && m_rready;
  assign len_err = w_beat && (m_rlast ? r_beat_cnt != r_len_q : r_beat_cnt == r_len_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx <= '0;
      r_last <= LW'(N - 1);
      r_beat_cnt <= '0;
      r_len_q <= '0;
    end else begin
      case (r_state)
        IDLE: if (|s_arvalid) begin
          r_grant <= N'(1) << w_pick;
          r_gidx <= w_pick;
          r_len_q <= s_arlen[w_pick*8 +: 8];
          r_state <= ADDR;
        end
        ADDR: if (m_arready) begin
          r_beat_cnt <= '0;
          r_state <= DATA;
        end
        DATA: begin
          if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;
          if (w_beat && m_rlast) begin
            r_last <= r_gidx;
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
